// File: rtl/tdm_demux.sv
// -----------------------------------------------------------------------------
// tdm_demux
//
// Receive-side time-division demultiplexer. It takes one channel-interleaved
// word stream that has a start-of-frame marker on the slot-0 word. Each word is
// steered into its own per-channel output register. The block tracks frame
// alignment, pulses frame_done once per complete frame, and flags framing
// errors.
//
// Parameters
//   NCH  number of time slots / channels per frame (2..16)
//   W    data word width in bits
//
// Ports
//   clk         system clock, rising-edge active
//   rst_n       asynchronous active-low reset
//   in_valid    in_data / in_sof qualify this cycle (gaps allowed)
//   in_sof      marks the slot-0 word of a frame (only with in_valid)
//   in_data     interleaved input word
//   err_clr     clears the sticky err_flag
//   out_data    channel i word at bits [i*W +: W], holds the last written value
//   out_valid   one-cycle pulse on the channel whose slice was just written
//   frame_done  one-cycle pulse when slot NCH-1 of a frame is written
//   frame_err   one-cycle pulse on a framing error
//   err_flag    sticky framing-error indicator
//
// All outputs are registered. Each output updates one cycle after the edge
// that samples the input.
// -----------------------------------------------------------------------------
module tdm_demux #(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [W-1:0]     in_data,
  input  logic             err_clr,
  output logic [NCH*W-1:0] out_data,
  output logic [NCH-1:0]   out_valid,
  output logic             frame_done,
  output logic             frame_err,
  output logic             err_flag
);

  localparam int             CW   = $clog2(NCH);
  localparam logic [CW-1:0]  LAST = CW'(NCH - 1);

  typedef enum logic {
    IDLE,  // waiting for a start-of-frame word
    RUN    // inside a frame, cnt_q is the next slot to fill
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [NCH*W-1:0] out_data_q;
  logic [NCH-1:0]   out_valid_q;
  logic             frame_done_q;
  logic             frame_err_q;
  logic             err_flag_q;

  logic             err_set;
  logic             err_flag_d;

  // A framing error occurs in two cases. The first is a data word that
  // arrives while no frame is open. The second is an SOF that arrives before
  // the current frame is complete.
  // NOTE: every signal assigned in always_comb gets a default first so that
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    err_set = 1'b0;
    if (in_valid) begin
      err_set = in_sof ? (state_q == RUN) : (state_q == IDLE);
    end
    // When a new error and err_clr occur in the same cycle, the error wins.
    // err_clr is honoured even when in_valid is low.
    err_flag_d = err_set | (err_flag_q & ~err_clr);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      // NOTE: the output word registers are architecturally visible and must
      // read zero after reset, so they are reset like control state.
      out_data_q   <= '0;
      out_valid_q  <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_flag_q   <= 1'b0;
    end else begin
      // Pulses default low; they are raised only by the cycle that causes them.
      out_valid_q  <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= err_set;
      err_flag_q   <= err_flag_d;

      if (in_valid) begin
        if (in_sof) begin
          // An SOF always opens a fresh frame. An SOF in RUN is an early SOF:
          // the truncated frame is abandoned without frame_done.
          out_data_q[0 +: W] <= in_data;
          out_valid_q[0]     <= 1'b1;
          cnt_q              <= CW'(1);
          state_q            <= RUN;
        end else if (state_q == RUN) begin
          out_data_q[cnt_q*W +: W] <= in_data;
          out_valid_q[cnt_q]       <= 1'b1;
          if (cnt_q == LAST) begin
            frame_done_q <= 1'b1;
            cnt_q        <= '0;
            state_q      <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // A non-SOF word in IDLE is dropped; err_set reports it.
      end
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign err_flag   = err_flag_q;

endmodule

// File: tb/tb_tdm_demux.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux
//
// Directed testbench for tdm_demux with NCH=4 and W=8. A frame model collects
// the words of the open frame into a growing list. Each new non-SOF word goes
// to the channel equal to the current list length. The model predicts every
// output one cycle after the input is sampled, and a compare process checks
// the DUT against it on every falling edge. Literal expectations in the
// stimulus sequence pin the model itself.
// -----------------------------------------------------------------------------
module tb_tdm_demux;

  localparam int NCH = 4;
  localparam int W   = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid = 1'b0;
  logic             in_sof = 1'b0;
  logic [W-1:0]     in_data = '0;
  logic             err_clr = 1'b0;
  logic [NCH*W-1:0] out_data;
  logic [NCH-1:0]   out_valid;
  logic             frame_done;
  logic             frame_err;
  logic             err_flag;

  tdm_demux #(.NCH(NCH), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .err_clr    (err_clr),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .err_flag   (err_flag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Frame model. m_frame holds the words of the frame currently being
  // received. An empty list means no frame is open.
  // ---------------------------------------------------------------------------
  logic [W-1:0]   m_frame[$];
  logic [W-1:0]   m_ch[NCH] = '{default: '0};
  logic [NCH-1:0] e_valid = '0;
  logic           e_done  = 1'b0;
  logic           e_ferr  = 1'b0;
  logic           e_flag  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_frame.delete();
      for (int i = 0; i < NCH; i++) m_ch[i] = '0;
      e_valid = '0;
      e_done  = 1'b0;
      e_ferr  = 1'b0;
      e_flag  = 1'b0;
    end else begin
      e_valid = '0;
      e_done  = 1'b0;
      e_ferr  = 1'b0;
      if (in_valid) begin
        if (in_sof) begin
          if (m_frame.size() != 0) e_ferr = 1'b1;  // truncated frame
          m_frame.delete();
          m_frame.push_back(in_data);
          m_ch[0]    = in_data;
          e_valid[0] = 1'b1;
        end else if (m_frame.size() == 0) begin
          e_ferr = 1'b1;                           // word outside any frame
        end else begin
          m_ch[m_frame.size()]    = in_data;
          e_valid[m_frame.size()] = 1'b1;
          m_frame.push_back(in_data);
          if (m_frame.size() == NCH) begin
            e_done = 1'b1;
            m_frame.delete();
          end
        end
      end
      if (e_ferr)       e_flag = 1'b1;
      else if (err_clr) e_flag = 1'b0;
    end
  end

  function automatic logic [NCH*W-1:0] model_data();
    logic [NCH*W-1:0] d;
    for (int i = 0; i < NCH; i++) d[i*W +: W] = m_ch[i];
    return d;
  endfunction

  // Compare process plus pulse counters used by the directed checks.
  int cyc = 0;
  int n_done = 0;
  int n_ferr = 0;
  int done_last = 0;
  int done_prev = 0;

  always @(negedge clk) begin
    cyc++;
    check("out_data", 64'(out_data), 64'(model_data()));
    check("out_valid", 64'(out_valid), 64'(e_valid));
    check("frame_done", 64'(frame_done), 64'(e_done));
    check("frame_err", 64'(frame_err), 64'(e_ferr));
    check("err_flag", 64'(err_flag), 64'(e_flag));
    if (frame_done === 1'b1) begin
      n_done++;
      done_prev = done_last;
      done_last = cyc;
    end
    if (frame_err === 1'b1) n_ferr++;
  end

  // One stimulus cycle. Inputs change just after the falling edge, so any
  // check that follows runs after the compare process for that edge.
  task automatic cycle(input logic v, input logic sof, input logic [W-1:0] d, input logic clr);
    @(negedge clk);
    #1;
    in_valid = v;
    in_sof   = sof;
    in_data  = d;
    err_clr  = clr;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic word(input logic sof, input logic [W-1:0] d);
    cycle(1'b1, sof, d, 1'b0);
  endtask

  int d0, f0;

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle();
    check("reset out_data", 64'(out_data), 64'h0);
    check("reset err_flag", 64'(err_flag), 64'h0);
    check("reset out_valid", 64'(out_valid), 64'h0);

    // Full frame on consecutive cycles.
    d0 = n_done; f0 = n_ferr;
    word(1'b1, 8'hA0);
    word(1'b0, 8'hA1);
    check("A slot0 valid", 64'(out_valid), 64'b0001);
    check("A slot0 data", 64'(out_data), 64'h0000_00A0);
    word(1'b0, 8'hA2);
    check("A slot1 valid", 64'(out_valid), 64'b0010);
    word(1'b0, 8'hA3);
    check("A slot2 valid", 64'(out_valid), 64'b0100);
    idle();
    check("A slot3 valid", 64'(out_valid), 64'b1000);
    check("A frame_done", 64'(frame_done), 64'h1);
    check("A out_data", 64'(out_data), 64'hA3A2_A1A0);
    check("A done count", 64'(n_done - d0), 64'd1);
    check("A err count", 64'(n_ferr - f0), 64'd0);

    // Same frame shape with two idle cycles between words.
    d0 = n_done; f0 = n_ferr;
    for (int i = 0; i < NCH; i++) begin
      word(i == 0, 8'(8'h10 + i));
      idle();
      if (i == 0) check("gap slot0 valid", 64'(out_valid), 64'b0001);
      idle();
      if (i == 0) check("gap hold", 64'(out_data), 64'hA3A2_A1_10);
      if (i == 0) check("gap no pulse", 64'(out_valid), 64'h0);
    end
    check("gap out_data", 64'(out_data), 64'h1312_1110);
    check("gap done count", 64'(n_done - d0), 64'd1);
    check("gap err count", 64'(n_ferr - f0), 64'd0);

    // Words without SOF straight after reset are dropped.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    f0 = n_ferr;
    word(1'b0, 8'h11);
    word(1'b0, 8'h22);
    idle();
    check("nosof out_data", 64'(out_data), 64'h0);
    check("nosof err_flag", 64'(err_flag), 64'h1);
    check("nosof err count", 64'(n_ferr - f0), 64'd2);
    cycle(1'b0, 1'b0, '0, 1'b1);
    idle();
    check("err_clr", 64'(err_flag), 64'h0);

    // Short frame: an early SOF truncates frame A.
    d0 = n_done; f0 = n_ferr;
    word(1'b1, 8'hA0);
    word(1'b0, 8'hA1);
    word(1'b1, 8'hB0);
    word(1'b0, 8'hB1);
    check("short err pulse", 64'(frame_err), 64'h1);
    word(1'b0, 8'hB2);
    word(1'b0, 8'hB3);
    idle();
    check("short out_data", 64'(out_data), 64'hB3B2_B1B0);
    check("short done count", 64'(n_done - d0), 64'd1);
    check("short err count", 64'(n_ferr - f0), 64'd1);

    // Two back-to-back frames.
    cycle(1'b0, 1'b0, '0, 1'b1);
    d0 = n_done; f0 = n_ferr;
    for (int i = 0; i < 2 * NCH; i++) word((i % NCH) == 0, 8'(8'h20 + 8'h10 * (i / NCH) + (i % NCH)));
    idle();
    check("b2b out_data", 64'(out_data), 64'h3332_3130);
    check("b2b done count", 64'(n_done - d0), 64'd2);
    check("b2b done spacing", 64'(done_last - done_prev), 64'd4);
    check("b2b err count", 64'(n_ferr - f0), 64'd0);
    check("b2b err_flag", 64'(err_flag), 64'h0);
    // An error in the same cycle as err_clr: the error wins.
    cycle(1'b1, 1'b0, 8'h55, 1'b1);
    idle();
    check("set wins", 64'(err_flag), 64'h1);
    check("set wins data", 64'(out_data), 64'h3332_3130);

    // Asynchronous reset in the middle of a frame.
    word(1'b1, 8'h40);
    word(1'b0, 8'h41);
    idle();
    check("pre-reset slot1", 64'(out_valid), 64'b0010);
    #1 rst_n = 1'b0;
    #1;
    check("async out_data", 64'(out_data), 64'h0);
    check("async out_valid", 64'(out_valid), 64'h0);
    check("async err_flag", 64'(err_flag), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = n_done; f0 = n_ferr;
    word(1'b0, 8'h77);
    idle();
    check("post-reset err", 64'(n_ferr - f0), 64'd1);
    check("post-reset flag", 64'(err_flag), 64'h1);
    for (int i = 0; i < NCH; i++) word(i == 0, 8'(8'h50 + i));
    idle();
    check("post-reset data", 64'(out_data), 64'h5352_5150);
    check("post-reset done", 64'(n_done - d0), 64'd1);

    repeat (2) idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
